regfile_mp: RTL and testbench

REGFILE_MP -- requirements
Module: regfile_mp

---
 rtl/rf_pkg.sv | 30 +++
 rtl/rf_scoreboard.sv | 48 ++++
 rtl/regfile_mp.sv | 86 ++++++++
 tb/tb_regfile_mp.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// rf_pkg: shared register-file definitions.
// Holds the ABI register index constants (x0, a0..a7) and the register
// index type used by regfile_mp and rf_scoreboard.
package rf_pkg;

  // Index width for the default 32-entry architectural file.
  localparam int REG_IDX_W = 5;

  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  // Hard-wired zero register and the ecall argument registers a0..a7.
  localparam reg_idx_t ZERO = 5'd0;
  localparam reg_idx_t A0   = 5'd10;
  localparam reg_idx_t A1   = 5'd11;
  localparam reg_idx_t A2   = 5'd12;
  localparam reg_idx_t A3   = 5'd13;
  localparam reg_idx_t A4   = 5'd14;
  localparam reg_idx_t A5   = 5'd15;
  localparam reg_idx_t A6   = 5'd16;
  localparam reg_idx_t A7   = 5'd17;

  // Number of argument registers exported for ecall handling.
  localparam int NUM_ABI_ARGS = 8;

  // Architectural index of argument register a<k>.
  function automatic int abi_reg(input int k);
    return int'(A0) + k;
  endfunction

endpackage

// File: rtl/rf_scoreboard.sv
// rf_scoreboard: one busy bit per architectural register.
// Issue sets a bit, any enabled writeback clears it; a same-cycle issue
// to the same register wins over the clear. Register 0 is never busy.
module rf_scoreboard
  import rf_pkg::*;
#(
  parameter  int NREGS = 32,
  parameter  int NWB   = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    iss_en,
  input  logic [AW-1:0]           iss_addr,
  input  logic [NWB-1:0]          wb_en,
  input  logic [NWB-1:0][AW-1:0]  wb_addr,
  output logic [NREGS-1:0]        busy_vec
);

  logic [NREGS-1:0] busy_q;
  logic [NREGS-1:0] busy_d;

  // Next busy state: clears from writebacks first, then the issue set on top.
  always_comb begin
    busy_d = busy_q;
    for (int p = 0; p < NWB; p++) begin
      if (wb_en[p]) begin
        busy_d[wb_addr[p]] = 1'b0;
      end
    end
    if (iss_en) begin
      busy_d[iss_addr] = 1'b1;
    end
    busy_d[ZERO] = 1'b0;
  end

  // Busy register; reset discards every outstanding write.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign busy_vec = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: multi-ported architectural register file with scoreboard.
// NRD combinational read ports, NWB writeback ports (highest index wins
// on an address collision), one issue port marking destinations busy.
// Optional feature macro: REGFILE_BYPASS_EN -- when defined, a read that
// matches an enabled writeback returns that writeback's data and not-busy
// in the same cycle; when undefined, reads see only stored state.
module regfile_mp
  import rf_pkg::*;
#(
  parameter  int XLEN  = 64,
  parameter  int NREGS = 32,
  parameter  int NRD   = 2,
  parameter  int NWB   = 2,
  localparam int AW    = $clog2(NREGS)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NRD-1:0][AW-1:0]            rd_addr,
  output logic [NRD-1:0][XLEN-1:0]          rd_data,
  output logic [NRD-1:0]                    rd_busy,
  input  logic [NWB-1:0]                    wb_en,
  input  logic [NWB-1:0][AW-1:0]            wb_addr,
  input  logic [NWB-1:0][XLEN-1:0]          wb_data,
  input  logic                              iss_en,
  input  logic [AW-1:0]                     iss_addr,
  output logic [NREGS-1:0]                  busy_vec,
  output logic [NUM_ABI_ARGS-1:0][XLEN-1:0] abi_args
);

  logic [XLEN-1:0] regs [NREGS];

  // Register storage: later writeback ports overwrite earlier ones, x0 is never written.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NREGS; r++) begin
        regs[r] <= '0;
      end
    end else begin
      for (int p = 0; p < NWB; p++) begin
        if (wb_en[p] && (wb_addr[p] != AW'(ZERO))) begin
          regs[wb_addr[p]] <= wb_data[p];
        end
      end
    end
  end

  rf_scoreboard #(
    .NREGS (NREGS),
    .NWB   (NWB)
  ) u_scoreboard (
    .clk      (clk),
    .reset    (reset),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .wb_en    (wb_en),
    .wb_addr  (wb_addr),
    .busy_vec (busy_vec)
  );

  // Read ports: stored value and busy bit, optionally overridden by a matching writeback.
  always_comb begin
    for (int i = 0; i < NRD; i++) begin
      rd_data[i] = regs[rd_addr[i]];
      rd_busy[i] = busy_vec[rd_addr[i]];
`ifdef REGFILE_BYPASS_EN
      for (int p = 0; p < NWB; p++) begin
        if (wb_en[p] && (wb_addr[p] == rd_addr[i]) && (rd_addr[i] != AW'(ZERO))) begin
          rd_data[i] = wb_data[p];
          rd_busy[i] = 1'b0;
        end
      end
`endif
    end
  end

  // ecall argument view always comes from committed storage, never bypassed.
  for (genvar k = 0; k < NUM_ABI_ARGS; k++) begin : g_abi
    localparam int IDX = abi_reg(k);
    if (IDX < NREGS) begin : g_present
      assign abi_args[k] = regs[IDX];
    end else begin : g_absent
      assign abi_args[k] = '0;
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed bench for regfile_mp with an abstract reference
// model (array of register values plus a busy flag per register) checked
// against every DUT output on each falling edge, plus literal checks.
module tb_regfile_mp;

  localparam int XLEN  = 64;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int NWB   = 2;
  localparam int AW    = 5;

  logic                         clk = 1'b0;
  logic                         reset;
  logic [NRD-1:0][AW-1:0]       rd_addr;
  logic [NRD-1:0][XLEN-1:0]     rd_data;
  logic [NRD-1:0]               rd_busy;
  logic [NWB-1:0]               wb_en;
  logic [NWB-1:0][AW-1:0]       wb_addr;
  logic [NWB-1:0][XLEN-1:0]     wb_data;
  logic                         iss_en;
  logic [AW-1:0]                iss_addr;
  logic [NREGS-1:0]             busy_vec;
  logic [7:0][XLEN-1:0]         abi_args;

  always #5 clk = ~clk;

  regfile_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD), .NWB(NWB)) dut (
    .clk      (clk),
    .reset    (reset),
    .rd_addr  (rd_addr),
    .rd_data  (rd_data),
    .rd_busy  (rd_busy),
    .wb_en    (wb_en),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data),
    .iss_en   (iss_en),
    .iss_addr (iss_addr),
    .busy_vec (busy_vec),
    .abi_args (abi_args)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: committed values and outstanding-write flags.
  logic [XLEN-1:0] m_regs [NREGS];
  bit              m_busy [NREGS];
  bit              m_valid = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      for (int r = 0; r < NREGS; r++) begin
        m_regs[r] = '0;
        m_busy[r] = 1'b0;
      end
      m_valid = 1'b1;
    end else if (m_valid) begin
      for (int r = 1; r < NREGS; r++) begin
        bit written;
        bit issued;
        written = 1'b0;
        for (int p = 0; p < NWB; p++) begin
          if (wb_en[p] && wb_addr[p] == AW'(r)) begin
            m_regs[r] = wb_data[p];
            written = 1'b1;
          end
        end
        issued = iss_en && (iss_addr == AW'(r));
        if (issued)       m_busy[r] = 1'b1;
        else if (written) m_busy[r] = 1'b0;
      end
    end
  end

  // Compare every output against the model mid-cycle.
  always @(negedge clk) begin
    if (m_valid) begin
      logic [XLEN-1:0] exp_bv;
      for (int i = 0; i < NRD; i++) begin
        logic [XLEN-1:0] ed;
        logic            eb;
        int              a;
        a  = int'(rd_addr[i]);
        ed = m_regs[a];
        eb = m_busy[a];
`ifdef REGFILE_BYPASS_EN
        if (a != 0) begin
          for (int p = 0; p < NWB; p++) begin
            if (wb_en[p] && wb_addr[p] == rd_addr[i]) begin
              ed = wb_data[p];
              eb = 1'b0;
            end
          end
        end
`endif
        check($sformatf("model rd_data[%0d] x%0d", i, a), rd_data[i], ed);
        check($sformatf("model rd_busy[%0d] x%0d", i, a), XLEN'(rd_busy[i]), XLEN'(eb));
      end
      exp_bv = '0;
      for (int r = 0; r < NREGS; r++) exp_bv[r] = m_busy[r];
      check("model busy_vec", XLEN'(busy_vec), exp_bv);
      for (int k = 0; k < 8; k++) begin
        check($sformatf("model abi_args[%0d]", k), abi_args[k], m_regs[10 + k]);
      end
    end
  end

  task automatic idle();
    wb_en    = '0;
    wb_addr  = '0;
    wb_data  = '0;
    iss_en   = 1'b0;
    iss_addr = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset   = 1'b1;
    rd_addr = '0;
    idle();
    tick();
    tick();
    reset = 1'b0;

    // After reset every register reads zero and nothing is busy.
    for (int r = 0; r < NREGS; r++) begin
      rd_addr[0] = AW'(r);
      rd_addr[1] = AW'(NREGS - 1 - r);
      #1;
      check($sformatf("reset rd0 x%0d", r), rd_data[0], 64'h0);
      check($sformatf("reset rd1 x%0d", NREGS - 1 - r), rd_data[1], 64'h0);
    end
    check("reset busy_vec", XLEN'(busy_vec), 64'h0);

    // Two ports write x5 in the same cycle: port 1 wins.
    tick();
    wb_en = 2'b11; wb_addr[0] = 5'd5; wb_data[0] = 64'hDEAD;
    wb_addr[1] = 5'd5; wb_data[1] = 64'hBEEF;
    tick();
    idle(); rd_addr[1] = 5'd5; #1;
    check("wb priority x5", rd_data[1], 64'hBEEF);

    // x0 ignores writes and issues.
    wb_en = 2'b01; wb_addr[0] = 5'd0; wb_data[0] = 64'h1234;
    iss_en = 1'b1; iss_addr = 5'd0;
    tick();
    idle(); rd_addr[0] = 5'd0; #1;
    check("x0 data", rd_data[0], 64'h0);
    check("x0 busy_vec[0]", XLEN'(busy_vec[0]), 64'h0);
    check("x0 rd_busy", XLEN'(rd_busy[0]), 64'h0);

    // Issue x7, then wb+issue x7 together, then a final wb clears it.
    iss_en = 1'b1; iss_addr = 5'd7;
    tick();
    idle(); rd_addr[0] = 5'd7; #1;
    check("x7 rd_busy after issue", XLEN'(rd_busy[0]), 64'h1);
    wb_en = 2'b01; wb_addr[0] = 5'd7; wb_data[0] = 64'h42;
    iss_en = 1'b1; iss_addr = 5'd7;
    tick();
    idle(); #1;
    check("x7 data after wb+iss", rd_data[0], 64'h42);
    check("x7 busy after wb+iss", XLEN'(busy_vec[7]), 64'h1);
    wb_en = 2'b10; wb_addr[1] = 5'd7; wb_data[1] = 64'h42;
    tick();
    idle(); #1;
    check("x7 busy after final wb", XLEN'(busy_vec[7]), 64'h0);

    // Read of x3 while it is being written back.
    wb_en = 2'b01; wb_addr[0] = 5'd3; wb_data[0] = 64'h11;
    iss_en = 1'b1; iss_addr = 5'd3;
    tick();
    idle();
    rd_addr[0] = 5'd3;
    wb_en = 2'b01; wb_addr[0] = 5'd3; wb_data[0] = 64'h99;
    #1;
`ifdef REGFILE_BYPASS_EN
    check("x3 same-cycle read", rd_data[0], 64'h99);
    check("x3 same-cycle busy", XLEN'(rd_busy[0]), 64'h0);
`else
    check("x3 same-cycle read", rd_data[0], 64'h11);
    check("x3 same-cycle busy", XLEN'(rd_busy[0]), 64'h1);
`endif
    tick();
    idle(); #1;
    check("x3 next-cycle read", rd_data[0], 64'h99);
    check("x3 next-cycle busy", XLEN'(rd_busy[0]), 64'h0);

    // Double issue to x9 is cleared by a single writeback.
    iss_en = 1'b1; iss_addr = 5'd9;
    tick();
    tick();
    idle(); #1;
    check("x9 busy after double issue", XLEN'(busy_vec[9]), 64'h1);
    wb_en = 2'b10; wb_addr[1] = 5'd9; wb_data[1] = 64'h5A5A_0000_1111_2222;
    tick();
    idle(); rd_addr[1] = 5'd9; #1;
    check("x9 busy after wb", XLEN'(busy_vec[9]), 64'h0);
    check("x9 data", rd_data[1], 64'h5A5A_0000_1111_2222);

    // Writeback to a register that was never issued.
    wb_en = 2'b01; wb_addr[0] = 5'd12; wb_data[0] = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    idle(); #1;
    check("x12 not busy", XLEN'(busy_vec[12]), 64'h0);

    // Fill a0..a7 with 1..8 over four cycles.
    for (int k = 0; k < 4; k++) begin
      wb_en = 2'b11;
      wb_addr[0] = AW'(10 + 2 * k); wb_data[0] = XLEN'(2 * k + 1);
      wb_addr[1] = AW'(11 + 2 * k); wb_data[1] = XLEN'(2 * k + 2);
      tick();
    end
    idle();
    iss_en = 1'b1; iss_addr = 5'd20;
    tick();
    idle(); rd_addr[0] = 5'd10; rd_addr[1] = 5'd20; #1;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("abi a%0d", k), abi_args[k], XLEN'(k + 1));
    end
    check("x20 busy before reset", XLEN'(rd_busy[1]), 64'h1);

    // Reset overrides a simultaneous writeback and issue.
    reset = 1'b1;
    wb_en = 2'b01; wb_addr[0] = 5'd10; wb_data[0] = 64'hFF;
    iss_en = 1'b1; iss_addr = 5'd21;
    tick();
    idle(); reset = 1'b0; #1;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("abi a%0d after reset", k), abi_args[k], 64'h0);
    end
    check("busy_vec after reset", XLEN'(busy_vec), 64'h0);
    check("x10 after reset", rd_data[0], 64'h0);
    check("x20 busy after reset", XLEN'(rd_busy[1]), 64'h0);

    tick();
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
